ids_dma_engine: RTL and testbench
=================================

// Module: ids_dma_engine
// PURPOSE
//  Word-copy DMA master driving the DMA master port of the DMEM-side bus
//  (lowest priority after SPI and RV DMEM). Copies N 32-bit words from src to dst,
//  typically PIM buffer (0x2xxx_xxxx) to Hybrid-PIM (0x4xxx_xxxx) or the reverse.
//  Started by a one-cycle start pulse from the core-side control register block.
// PARAMETERS
//  LEN_W     16   width of word-count field; max transfer = 2**LEN_W-1 words
//  MAX_WAIT  255  grant-wait cycles per beat before abort with error (0 = no timeout)
// PORTS
//  i_clk        in   1       clock
//  i_rst        in   1       synchronous reset, active-high
//  i_start      in   1       start pulse; sampled only in IDLE
//  i_src_addr   in   32      source byte address; bits[1:0] ignored (forced 0)
//  i_dst_addr   in   32      destination byte address; bits[1:0] ignored
//  i_len        in   LEN_W   number of words to copy
//  o_busy       out  1       high from cycle after accepted start until DONE exits
//  o_done       out  1       one-cycle pulse at end of transfer (incl. len==0, abort)
//  o_err        out  1       sticky: last transfer aborted on timeout; cleared by start
//  o_req_dma    out  1       bus request
//  i_gnt_dma    in   1       bus grant (same-cycle response to o_req_dma)
//  o_dma_addr   out  32      bus address
//  o_dma_write  out  1       bus write strobe
//  o_dma_read   out  1       bus read strobe
//  o_dma_size   out  4       byte enables; always 4'hF when read/write asserted
//  o_dma_din    out  32      write data to bus
//  i_dma_dout   in   32      read data from bus, valid the cycle after a granted read
// BEHAVIOUR
//  Reset (sync, i_rst=1 at posedge): state=IDLE; all outputs 0; counters, data reg 0.
//  Beat = bus cycle with o_req_dma && i_gnt_dma. Strobes/addr held until granted.
//  FSM:
//   IDLE : i_start -> latch src/dst (bits[1:0]=0), cnt=i_len, clear o_err;
//          cnt==0 -> DONE, else -> RD. start ignored in all other states.
//   RD   : req=1, read=1, addr=src. On grant -> CAP. Not granted -> stay, wait++.
//   CAP  : req=0, read=0, addr held = src; data_q <= i_dma_dout. -> WR.
//   WR   : req=1, write=1, addr=dst, din=data_q. On grant: src+=4, dst+=4, cnt-=1;
//          cnt==1 (last word) -> DONE, else -> RD. Not granted -> stay, wait++.
//   DONE : o_done=1 for exactly this cycle, busy=0 next -> IDLE.
//  Grant-wait counter resets on every state entry; if MAX_WAIT!=0 and it reaches
//   MAX_WAIT in RD/WR: drop req, o_err=1, -> DONE (remaining words not copied).
//  Throughput: 3 cycles/word with continuous grant; total = 3*len + 2 cycles
//   start-to-done (start cycle, len beats x3, DONE cycle).
//  Addresses wrap modulo 2**32; no region-boundary checks (bus decodes [31:28]).
//  o_dma_read and o_dma_write never both high; both low outside RD/WR.
//  o_busy = (state != IDLE) excluding DONE cycle handling: high in RD/CAP/WR/DONE.
//  Reset mid-transfer: abort immediately, no done pulse, outputs 0 next cycle.
//  Grant loss between RD and CAP is harmless: read data already captured by bus
//   address latch; CAP never re-requests.
// TESTING
//  T1 len=4, src=0x2000_0000, dst=0x4000_0010, gnt tied 1 -> 4 reads/4 writes, dst
//     words = src words, o_done at cycle 14 after start, o_err=0.
//  T2 len=0 start -> no req asserted, o_done pulses 1 cycle after start.
//  T3 len=3, gnt low 5 cycles during 2nd WR -> strobes/addr/din held stable, data
//     correct, done delayed by exactly 5 cycles.
//  T4 MAX_WAIT=8, gnt stuck 0 -> req drops after 8 RD cycles, o_err=1, o_done pulse;
//     next start clears o_err.
//  T5 i_start pulsed while busy with different addrs -> ignored, original copy
//     completes unchanged.
//  T6 i_rst asserted in WR of word 2 of 6 -> next cycle all outputs 0, IDLE, no done;
//     src_addr 0x2000_0003 -> first read at 0x2000_0000 (alignment forced).

Source files
------------

// File: rtl/ids_dma_engine.sv
// Word-copy DMA master: reads one word, captures it, writes it, and repeats
// for len words, with a per-beat grant timeout that aborts the transfer.
module ids_dma_engine #(
   parameter int LEN_W    = 16,
   parameter int MAX_WAIT = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [31:0]      i_src_addr,
   input  logic [31:0]      i_dst_addr,
   input  logic [LEN_W-1:0] i_len,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic             o_req_dma,
   input  logic             i_gnt_dma,
   output logic [31:0]      o_dma_addr,
   output logic             o_dma_write,
   output logic             o_dma_read,
   output logic [3:0]       o_dma_size,
   output logic [31:0]      o_dma_din,
   input  logic [31:0]      i_dma_dout,
   output logic [2:0]       o_dbg_state
);

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        src_q, src_d;
   logic [31:0]        dst_q, dst_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [31:0]        data_q, data_d;
   logic               err_q, err_d;
   logic               timeout;

   logic               busy_d, done_d, req_d, rd_d, wr_d;
   logic [31:0]        addr_d, din_d;
   logic [3:0]         size_d;

   assign timeout = (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT - 1));

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               src_d   = {i_src_addr[31:2], 2'b00};
               dst_d   = {i_dst_addr[31:2], 2'b00};
               cnt_d   = i_len;
               err_d   = 1'b0;
               state_d = (i_len == '0) ? S_DONE : S_RD;
            end
         end
         S_RD: begin
            if (i_gnt_dma) begin
               state_d = S_CAP;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_CAP: begin
            data_d  = i_dma_dout;
            state_d = S_WR;
         end
         S_WR: begin
            if (i_gnt_dma) begin
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_RD;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) wait_d = '0;
   end

   // Bus outputs are decoded from the next state so they are registered
   // and appear in the same cycle the FSM enters RD/CAP/WR.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      rd_d   = (state_d == S_RD);
      wr_d   = (state_d == S_WR);
      req_d  = rd_d || wr_d;
      size_d = req_d ? 4'hF : 4'h0;
      din_d  = wr_d ? data_d : 32'd0;
      addr_d = 32'd0;
      if (wr_d) addr_d = dst_d;
      else if (rd_d || (state_d == S_CAP)) addr_d = src_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         wait_q      <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_req_dma   <= 1'b0;
         o_dma_read  <= 1'b0;
         o_dma_write <= 1'b0;
         o_dma_size  <= 4'h0;
         o_dma_addr  <= '0;
         o_dma_din   <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         data_q      <= data_d;
         err_q       <= err_d;
         o_busy      <= busy_d;
         o_done      <= done_d;
         o_req_dma   <= req_d;
         o_dma_read  <= rd_d;
         o_dma_write <= wr_d;
         o_dma_size  <= size_d;
         o_dma_addr  <= addr_d;
         o_dma_din   <= din_d;
      end
   end

   assign o_err       = err_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ids_dma_engine.sv
// Bench for ids_dma_engine: table of transfers with a bus responder and a
// read/write scoreboard, plus a hand-written mid-transfer reset sequence.
module tb_ids_dma_engine;

   localparam int LEN_W = 16;

   logic              clk = 1'b0;
   logic              i_rst, i_start, i_gnt_dma;
   logic [31:0]       i_src_addr, i_dst_addr, i_dma_dout;
   logic [LEN_W-1:0]  i_len;
   logic              o_busy, o_done, o_err, o_req_dma, o_dma_write, o_dma_read;
   logic [31:0]       o_dma_addr, o_dma_din;
   logic [3:0]        o_dma_size;
   logic [2:0]        o_dbg_state;

   always #5 clk = ~clk;

   ids_dma_engine #(.LEN_W(LEN_W), .MAX_WAIT(8)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
      .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_req_dma(o_req_dma), .i_gnt_dma(i_gnt_dma), .o_dma_addr(o_dma_addr),
      .o_dma_write(o_dma_write), .o_dma_read(o_dma_read), .o_dma_size(o_dma_size),
      .o_dma_din(o_dma_din), .i_dma_dout(i_dma_dout), .o_dbg_state(o_dbg_state)
   );

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          stall_beat;
      int          stall_len;
      bit          stuck;
      bit          poke;
      int          exp_cycles;
      bit          exp_err;
      int          exp_req;
   } vec_t;

   vec_t        tbl [7];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_wr_q [$];
   logic [31:0] exp_rd_q [$];

   bit          rd_gnt_prev;
   logic [31:0] rd_addr_prev;
   int          wr_idx, stall_beat, stall_len, stall_cnt, req_cycles;
   bit          stuck, excl_ok;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check32({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
      check32({tag, "_done"},  {31'd0, o_done}, 32'd0);
      check32({tag, "_req"},   {31'd0, o_req_dma}, 32'd0);
      check32({tag, "_strb"},  {30'd0, o_dma_read, o_dma_write}, 32'd0);
      check32({tag, "_addr"},  o_dma_addr, 32'd0);
      check32({tag, "_din"},   o_dma_din, 32'd0);
      check32({tag, "_size"},  {28'd0, o_dma_size}, 32'd0);
      check32({tag, "_state"}, {29'd0, o_dbg_state}, 32'd0);
   endtask

   task automatic push_expected(input logic [31:0] src, input logic [31:0] dst, input int len);
      logic [31:0] s, d;
      s = {src[31:2], 2'b00};
      d = {dst[31:2], 2'b00};
      for (int k = 0; k < len; k++) begin
         exp_rd_q.push_back(s);
         exp_wr_q.push_back({d, mem_word(s)});
         s = s + 32'd4;
         d = d + 32'd4;
      end
   endtask

   // Called at each negedge: returns read data, decides grant, scores strobes.
   task automatic bus_step();
      bit gnt;
      i_dma_dout = rd_gnt_prev ? mem_word(rd_addr_prev) : $urandom;
      rd_gnt_prev = 1'b0;
      gnt = !stuck;
      if (o_dma_read && o_dma_write) excl_ok = 1'b0;
      if (o_req_dma) begin
         req_cycles++;
         if (o_dma_write && wr_idx == stall_beat && stall_cnt < stall_len) begin
            gnt = 1'b0;
            stall_cnt++;
         end
         check32("size", {28'd0, o_dma_size}, 32'hF);
         if (o_dma_read) begin
            if (exp_rd_q.size() == 0) check32("rd_unexpected", o_dma_addr, 32'hDEAD_BEEF);
            else begin
               check32("rd_addr", o_dma_addr, exp_rd_q[0]);
               if (gnt) void'(exp_rd_q.pop_front());
            end
            rd_gnt_prev  = gnt;
            rd_addr_prev = o_dma_addr;
         end
         if (o_dma_write) begin
            if (exp_wr_q.size() == 0) check32("wr_unexpected", o_dma_addr, 32'hDEAD_BEEF);
            else begin
               check32("wr_addr", o_dma_addr, exp_wr_q[0][63:32]);
               check32("wr_data", o_dma_din, exp_wr_q[0][31:0]);
               if (gnt) begin
                  void'(exp_wr_q.pop_front());
                  wr_idx++;
               end
            end
         end
      end
      i_gnt_dma = gnt;
   endtask

   initial begin
      int cycles;
      bit done, busy_ok;
      vec_t e;

      tbl[0] = '{32'h2000_0000, 32'h4000_0010, 4, -1, 0, 1'b0, 1'b0, 14, 1'b0, 8};
      tbl[1] = '{32'h4000_0103, 32'h2000_0202, 1, -1, 0, 1'b0, 1'b0,  5, 1'b0, 2};
      tbl[2] = '{32'h2000_0040, 32'h4000_0080, 3,  1, 5, 1'b0, 1'b0, 16, 1'b0, 11};
      tbl[3] = '{32'h2000_0000, 32'h4000_0000, 0, -1, 0, 1'b0, 1'b0,  2, 1'b0, 0};
      tbl[4] = '{32'h2000_1000, 32'h4000_1000, 5, -1, 0, 1'b1, 1'b0, 10, 1'b1, 8};
      tbl[5] = '{32'h2000_2000, 32'h4000_2000, 2, -1, 0, 1'b0, 1'b1,  8, 1'b0, 4};
      tbl[6] = '{32'hFFFF_FFF8, 32'h3FFF_FFFC, 3, -1, 0, 1'b0, 1'b1, 11, 1'b0, 6};

      i_rst = 1'b1; i_start = 1'b0; i_gnt_dma = 1'b1;
      i_src_addr = '0; i_dst_addr = '0; i_len = '0; i_dma_dout = '0;
      rd_gnt_prev = 1'b0; rd_addr_prev = '0; stuck = 1'b0;
      stall_beat = -1; stall_len = 0; stall_cnt = 0; wr_idx = 0;
      req_cycles = 0; excl_ok = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check32("reset_err", {31'd0, o_err}, 32'd0);
      i_rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         e = tbl[v];
         @(negedge clk);
         stuck = e.stuck; stall_beat = e.stall_beat; stall_len = e.stall_len;
         stall_cnt = 0; wr_idx = 0; req_cycles = 0; excl_ok = 1'b1; busy_ok = 1'b1;
         push_expected(e.src, e.dst, e.len);
         i_start = 1'b1; i_src_addr = e.src; i_dst_addr = e.dst; i_len = LEN_W'(e.len);
         bus_step();
         cycles = 1; done = 1'b0;
         while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            i_start = e.poke && (cycles == 4);
            if (i_start) begin
               i_src_addr = $urandom; i_dst_addr = $urandom;
               i_len = LEN_W'($urandom_range(1, 9));
            end
            if (!o_busy) busy_ok = 1'b0;
            bus_step();
            if (o_done) done = 1'b1;
         end
         i_start = 1'b0;
         check32($sformatf("v%0d_done_cycle", v), cycles, e.exp_cycles);
         check32($sformatf("v%0d_err", v), {31'd0, o_err}, {31'd0, e.exp_err});
         check32($sformatf("v%0d_req_cycles", v), req_cycles, e.exp_req);
         check32($sformatf("v%0d_busy", v), {31'd0, busy_ok}, 32'd1);
         check32($sformatf("v%0d_rw_excl", v), {31'd0, excl_ok}, 32'd1);
         @(negedge clk);
         bus_step();
         check32($sformatf("v%0d_done_pulse", v), {31'd0, o_done}, 32'd0);
         check32($sformatf("v%0d_idle_busy", v), {31'd0, o_busy}, 32'd0);
         check32($sformatf("v%0d_err_sticky", v), {31'd0, o_err}, {31'd0, e.exp_err});
         if (e.exp_err) begin
            exp_rd_q.delete();
            exp_wr_q.delete();
         end else begin
            check32($sformatf("v%0d_rd_left", v), exp_rd_q.size(), 32'd0);
            check32($sformatf("v%0d_wr_left", v), exp_wr_q.size(), 32'd0);
         end
      end

      // Reset while the second word's write is on the bus.
      @(negedge clk);
      stuck = 1'b0; stall_beat = -1; stall_len = 0; wr_idx = 0;
      push_expected(32'h2000_0003, 32'h4000_0000, 6);
      i_start = 1'b1; i_src_addr = 32'h2000_0003; i_dst_addr = 32'h4000_0000; i_len = 16'd6;
      bus_step();
      @(negedge clk);
      i_start = 1'b0;
      cycles = 0;
      while (!(o_dma_write && wr_idx == 1) && cycles < 100) begin
         bus_step();
         @(negedge clk);
         cycles++;
      end
      check32("rst_reached_wr2", {31'd0, o_dma_write}, 32'd1);
      i_rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("midrst");
      i_rst = 1'b0;
      done = 1'b0; req_cycles = 0;
      repeat (5) begin
         @(negedge clk);
         if (o_done) done = 1'b1;
         if (o_req_dma) req_cycles++;
      end
      check32("midrst_no_done", {31'd0, done}, 32'd0);
      check32("midrst_no_req", req_cycles, 32'd0);
      exp_rd_q.delete();
      exp_wr_q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
